// File: rtl/pokey_clk_pkg.sv
// Shared divider defaults and counter-width helper for the POKEY tick generator.
// Pure constants; no latency, no backpressure.
package pokey_clk_pkg;

    localparam int NUM_CH_DEF  = 4;
    localparam int DIV_64K_DEF = 28;
    localparam int DIV_15K_DEF = 114;
    localparam int CNT_W_DEF   = 7;

    // Bits needed to hold div-1.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/pokey_tick_gen_if.sv
// Tick-generator control/tick bundle: master drives enables/selects, slave returns ticks.
// Ticks are one-clk pulses; there is no backpressure on this bundle.
interface pokey_tick_gen_if
    import pokey_clk_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
);
    logic              ph2_en;
    logic              init;
    logic              sel15Khz;
    logic [NUM_CH-1:0] fast_sel;
    logic [NUM_CH-1:0] aud_tick;
    logic              keyb_tick;

    modport master (
        output ph2_en, init, sel15Khz, fast_sel,
        input  aud_tick, keyb_tick
    );

    modport slave (
        input  ph2_en, init, sel15Khz, fast_sel,
        output aud_tick, keyb_tick
    );
endinterface

// File: rtl/tick_divider.sv
// Modulo-DIV enable counter; combinational tick in the enabled cycle that wraps.
// Zero latency tick, clr holds the count at 0 and masks the tick; no backpressure.
module tick_divider
    import pokey_clk_pkg::*;
#(
    parameter int DIV   = DIV_64K_DEF,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    if (CNT_W < cnt_width(DIV)) begin : g_width_chk
        $error("tick_divider: CNT_W too small for DIV");
    end

    assign wrap = (cnt == LAST);
    assign tick = en & ~clr & wrap;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pokey_tick_gen.sv
// POKEY 64k/15k base-tick divider with per-channel audio tick select and keyboard tick.
// Outputs registered, 1 clk after the causing ph2_en; no backpressure. Option: POKEY_TICK_ALIGN_EN.
module pokey_tick_gen
    import pokey_clk_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DIV_64K = DIV_64K_DEF,
    parameter int DIV_15K = DIV_15K_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pokey_tick_gen_if.slave   bus
);
    logic              t64;
    logic              t15;
    logic              base;
    logic              clr;
    logic [NUM_CH-1:0] aud_next;

`ifdef POKEY_TICK_ALIGN_EN
    // A select change restarts both dividers so the new base starts with a full period.
    logic sel_q;

    always_ff @(posedge clk) begin
        sel_q <= bus.sel15Khz;
    end

    assign clr = bus.init | (bus.sel15Khz ^ sel_q);
`else
    assign clr = bus.init;
`endif

    tick_divider #(
        .DIV   (DIV_64K),
        .CNT_W (CNT_W)
    ) u_div_64k (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (bus.ph2_en),
        .tick  (t64)
    );

    tick_divider #(
        .DIV   (DIV_15K),
        .CNT_W (CNT_W)
    ) u_div_15k (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (bus.ph2_en),
        .tick  (t15)
    );

    assign base = bus.sel15Khz ? t15 : t64;

    always_comb begin
        aud_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            aud_next[i] = bus.fast_sel[i] ? bus.ph2_en : base;
        end
    end

    // init silences every output, fast channels included.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.aud_tick  <= '0;
            bus.keyb_tick <= 1'b0;
        end else if (bus.init) begin
            bus.aud_tick  <= '0;
            bus.keyb_tick <= 1'b0;
        end else begin
            bus.aud_tick  <= aud_next;
            bus.keyb_tick <= t15;
        end
    end

endmodule
